seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Sequential ALU: single-cycle ops finish one edge after capture; multiply/divide
// iterate one bit per cycle (WIDTH+1 edges). No backpressure: start is dropped unless idle.
module seq_alu #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       sel,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done
);

  localparam int              M    = WIDTH - 1;
  localparam int              CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST = CW'(WIDTH);
  localparam logic [WIDTH-1:0] WMOD = WIDTH'(WIDTH);
  localparam logic [WIDTH:0]  ONE  = {{WIDTH{1'b0}}, 1'b1};

  typedef enum logic [1:0] {IDLE, ITER, FIN} state_t;

  state_t           state, state_nxt;
  logic             armed, pend, accept, sel_iter;
  logic [3:0]       opsel;
  logic [WIDTH-1:0] opa, opb, hi, lo;
  logic [CW-1:0]    cnt;

  // armed stays low for the first edge after reset release so a start there is dropped
  assign sel_iter = (sel == 4'd12) || (sel == 4'd13) || (sel == 4'd14);
  assign accept   = start && armed && (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept && sel_iter) state_nxt = ITER;
      ITER:    if (cnt == LAST) state_nxt = FIN;
      FIN:     state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  logic [WIDTH:0]   add_x, sub_x, inc_x, dec_x, shl_x, shr_x;
  logic [WIDTH-1:0] samt, rol, res;
  logic             res_c, res_v, res_wr;

  assign add_x = {1'b0, opa} + {1'b0, opb};
  assign sub_x = {1'b0, opa} - {1'b0, opb};
  assign inc_x = {1'b0, opa} + ONE;
  assign dec_x = {1'b0, opa} - ONE;
  assign samt  = opb % WMOD;
  // the extra bit on each side catches the last bit shifted out
  assign shl_x = {1'b0, opa} << samt;
  assign shr_x = {opa, 1'b0} >> samt;
  assign rol   = (opa << samt) | (opa >> (WMOD - samt));

  always_comb begin
    res    = opa;
    res_c  = 1'b0;
    res_v  = 1'b0;
    res_wr = 1'b1;
    case (opsel)
      4'd0:  res = opa;
      4'd1:  res = opa & opb;
      4'd2:  res = opa | opb;
      4'd3:  res = ~opa;
      4'd4: begin
        {res_c, res} = add_x;
        res_v = (opa[M] == opb[M]) && (add_x[M] != opa[M]);
      end
      4'd5: begin
        {res_c, res} = sub_x;
        res_v = (opa[M] != opb[M]) && (sub_x[M] != opa[M]);
      end
      4'd6: begin
        {res_c, res} = inc_x;
        res_v = !opa[M] && inc_x[M];
      end
      4'd7: begin
        {res_c, res} = dec_x;
        res_v = opa[M] && !dec_x[M];
      end
      4'd8:  res = opa ^ opb;
      4'd9:  {res_c, res} = shl_x;
      4'd10: {res, res_c} = shr_x;
      4'd11: res = rol;
      4'd15: begin
        {res_c, res} = sub_x;
        res_v  = (opa[M] != opb[M]) && (sub_x[M] != opa[M]);
        res_wr = 1'b0;
      end
      default: res_wr = 1'b0;
    endcase
  end

  // {hi,lo} is the shift-add product for multiply, {remainder,quotient} for divide
  logic [WIDTH:0]   mul_sum, div_sh, div_dif;
  logic             div_ge, ires_c;
  logic [WIDTH-1:0] ires;

  assign mul_sum = {1'b0, hi} + (lo[0] ? {1'b0, opb} : {(WIDTH+1){1'b0}});
  assign div_sh  = {hi, lo[M]};
  assign div_dif = div_sh - {1'b0, opb};
  assign div_ge  = !div_dif[WIDTH];
  assign ires    = (opsel == 4'd14) ? hi : lo;
  assign ires_c  = (opsel == 4'd12) ? (hi != '0) : (opb == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      armed <= 1'b0;
      pend  <= 1'b0;
      opsel <= '0;
      opa   <= '0;
      opb   <= '0;
      hi    <= '0;
      lo    <= '0;
      cnt   <= '0;
      out   <= '0;
      flags <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      armed <= 1'b1;
      done  <= 1'b0;
      pend  <= 1'b0;
      if (accept) begin
        opa   <= a;
        opb   <= b;
        opsel <= sel;
        pend  <= !sel_iter;
        hi    <= '0;
        lo    <= a;
        cnt   <= '0;
      end
      if (pend) begin
        done  <= 1'b1;
        flags <= {res[M], res == '0, res_c, res_v};
        if (res_wr) out <= res;
      end
      if (state == ITER) begin
        if (cnt != LAST) begin
          busy <= 1'b1;
          cnt  <= cnt + CW'(1);
          if (opsel == 4'd12) begin
            {hi, lo} <= {mul_sum, lo[M:1]};
          end else begin
            hi <= div_ge ? div_dif[M:0] : div_sh[M:0];
            lo <= {lo[M-1:0], div_ge};
          end
        end else begin
          busy  <= 1'b0;
          done  <= 1'b1;
          out   <= ires;
          flags <= {ires[M], ires == '0, ires_c, 1'b0};
        end
      end
    end
  end

endmodule
